month_year: RTL

- Calendar stage directly downstream of the day counter.
- Consumes the day counter's end_of_month flag and advances month 1..12 and a 4-digit year.
- Feeds month and leap_year back to the day counter for its max-days lookup.
- Provides manual month/year advance inputs for the time-setting UI. Exports end_of_year for any year-level consumer.

---
 rtl/month_year.sv | 85 ++++++++
 1 files changed

// File: rtl/month_year.sv
// Calendar month/year stage fed by the day counter's end_of_month level.
// Advances month 1..12 and a binary year 0..9999, derives the Gregorian
// leap-year flag from modulo trackers, and accepts manual month/year advances.
module month_year #(
    parameter int BASE_YEAR = 2000,
    parameter int YEAR_W    = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              end_of_month,
    input  logic              month_offset,
    input  logic              year_offset,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic              leap_year,
    output logic              end_of_year
);

    localparam logic [YEAR_W-1:0] YEAR_INIT = YEAR_W'(BASE_YEAR);
    localparam logic [YEAR_W-1:0] YEAR_MAX  = YEAR_W'(9999);
    localparam logic [1:0]        Y4_INIT   = 2'(BASE_YEAR % 4);
    localparam logic [6:0]        Y100_INIT = 7'(BASE_YEAR % 100);
    localparam logic [8:0]        Y400_INIT = 9'(BASE_YEAR % 400);

    logic       eom_prev;
    logic       mo_prev;
    logic       yr_prev;
    logic       eom_edge;
    logic       mo_edge;
    logic       yr_edge;
    logic       month_evt;
    logic       year_evt;
    logic [1:0] y4;
    logic [6:0] y100;
    logic [8:0] y400;

    assign eom_edge  = end_of_month & ~eom_prev;
    assign mo_edge   = month_offset & ~mo_prev;
    assign yr_edge   = year_offset  & ~yr_prev;
    // A manual month advance can wrap December but never carries into the year.
    assign month_evt = eom_edge | mo_edge;
    assign year_evt  = ((month == 4'd12) & eom_edge) | yr_edge;

    // Leap year from the trackers; valid in the same cycle the year changes.
    assign leap_year = ((y4 == 2'd0) && (y100 != 7'd0)) || (y400 == 9'd0);

    // Edge history, month/year counters, year-rollover flag and modulo trackers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eom_prev    <= 1'b0;
            mo_prev     <= 1'b0;
            yr_prev     <= 1'b0;
            month       <= 4'd1;
            year        <= YEAR_INIT;
            end_of_year <= 1'b0;
            y4          <= Y4_INIT;
            y100        <= Y100_INIT;
            y400        <= Y400_INIT;
        end else begin
            eom_prev <= end_of_month;
            mo_prev  <= month_offset;
            yr_prev  <= year_offset;

            if (month_evt) begin
                if (month == 4'd12) begin
                    month       <= 4'd1;
                    // Only a real December rollover flags end of year.
                    end_of_year <= eom_edge;
                end else begin
                    month       <= month + 4'd1;
                    end_of_year <= 1'b0;
                end
            end

            if (year_evt) begin
                // 10000 is a multiple of 400, so the trackers stay aligned across the wrap.
                year <= (year == YEAR_MAX) ? '0 : year + YEAR_W'(1);
                y4   <= y4 + 2'd1;
                y100 <= (y100 == 7'd99)  ? 7'd0 : y100 + 7'd1;
                y400 <= (y400 == 9'd399) ? 9'd0 : y400 + 9'd1;
            end
        end
    end

endmodule
